// File: rtl/draw_players_n.sv
// N-player sprite overlay stage: two-stage pipeline that composites fixed-priority
// player rectangles over the upstream pixel and reports per-frame player overlap.
module draw_players_n #(
    parameter int N_PLAYERS = 2,
    parameter int PLAYER_W  = 48,
    parameter int PLAYER_H  = 64,
    parameter int POS_W     = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [10:0]                  hcount_in,
    input  logic [10:0]                  vcount_in,
    input  logic                         hsync_in,
    input  logic                         vsync_in,
    input  logic                         hblnk_in,
    input  logic                         vblnk_in,
    input  logic [11:0]                  rgb_in,
    input  logic [N_PLAYERS*POS_W-1:0]   xpos_in,
    input  logic [N_PLAYERS*POS_W-1:0]   ypos_in,
    input  logic [N_PLAYERS-1:0]         enable_in,
    input  logic [N_PLAYERS*12-1:0]      colour_in,
    output logic [10:0]                  hcount_out,
    output logic [10:0]                  vcount_out,
    output logic                         hsync_out,
    output logic                         vsync_out,
    output logic                         hblnk_out,
    output logic                         vblnk_out,
    output logic [11:0]                  rgb_out,
    output logic [N_PLAYERS-1:0]         collide_out,
    output logic                         frame_tick
);

    localparam int PW = POS_W + 1;

    logic [N_PLAYERS*POS_W-1:0] x_s, y_s;
    logic [N_PLAYERS-1:0]       en_s;
    logic [N_PLAYERS*12-1:0]    col_s;
    logic                       vblnk_prev;
    logic                       vblnk_rise;
    logic [N_PLAYERS-1:0]       acc;

    logic [N_PLAYERS-1:0]       hit_c, hit_r;
    logic                       multi_hit;
    logic [10:0]                hcount_1, vcount_1;
    logic                       hsync_1, vsync_1, hblnk_1, vblnk_1;
    logic [11:0]                rgb_1;
    logic [11:0]                win_col;
    logic [11:0]                rgb_next;

    assign vblnk_rise = vblnk_in & ~vblnk_prev;

    // Compare in POS_W+1 bits so a sprite near the right/bottom edge is clipped, not wrapped.
    always_comb begin
        hit_c = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            logic [PW-1:0] hc, vc, xl, yl;
            hc = PW'(hcount_in);
            vc = PW'(vcount_in);
            xl = PW'(x_s[i*POS_W +: POS_W]);
            yl = PW'(y_s[i*POS_W +: POS_W]);
            hit_c[i] = en_s[i] & ~hblnk_in & ~vblnk_in
                     & (hc >= xl) & (hc < xl + PW'(PLAYER_W))
                     & (vc >= yl) & (vc < yl + PW'(PLAYER_H));
        end
    end

    // Clearing the lowest set bit leaves something only when two or more players hit.
    assign multi_hit = |(hit_c & (hit_c - 1'b1));

    // Descending scan so the lowest-index hit is the one left standing.
    always_comb begin
        win_col = 12'h000;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (hit_r[i]) win_col = col_s[i*12 +: 12];
        end
    end

    always_comb begin
        rgb_next = rgb_1;
        if (hblnk_1 | vblnk_1) rgb_next = 12'h000;
        else if (|hit_r)       rgb_next = win_col;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_s         <= '0;
            y_s         <= '0;
            en_s        <= '0;
            col_s       <= '0;
            vblnk_prev  <= 1'b0;
            acc         <= '0;
            collide_out <= '0;
            frame_tick  <= 1'b0;
        end else begin
            vblnk_prev <= vblnk_in;
            frame_tick <= vblnk_rise;
            if (vblnk_rise) begin
                x_s         <= xpos_in;
                y_s         <= ypos_in;
                en_s        <= enable_in;
                col_s       <= colour_in;
                collide_out <= acc;
                acc         <= '0;
            end else if (multi_hit) begin
                acc <= acc | hit_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_r      <= '0;
            hcount_1   <= '0;
            vcount_1   <= '0;
            hsync_1    <= 1'b0;
            vsync_1    <= 1'b0;
            hblnk_1    <= 1'b0;
            vblnk_1    <= 1'b0;
            rgb_1      <= '0;
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hit_r      <= hit_c;
            hcount_1   <= hcount_in;
            vcount_1   <= vcount_in;
            hsync_1    <= hsync_in;
            vsync_1    <= vsync_in;
            hblnk_1    <= hblnk_in;
            vblnk_1    <= vblnk_in;
            rgb_1      <= rgb_in;
            hcount_out <= hcount_1;
            vcount_out <= vcount_1;
            hsync_out  <= hsync_1;
            vsync_out  <= vsync_1;
            hblnk_out  <= hblnk_1;
            vblnk_out  <= vblnk_1;
            rgb_out    <= rgb_next;
        end
    end

endmodule
